regfile_dump: RTL and testbench

Debug reader for the processor's 32×32 register file. On a `start` pulse it walks a contiguous, wrapping range of register addresses through a spare combinational read port. For each register it emits a 5-byte record on a byte-wide valid/ready stream: the address byte, then the 4 data bytes MSB-first. It sits between the register file's read side and the debug UART transmitter, and never writes the register file.

---
 rtl/regfile_dump_if.sv | 9 +
 rtl/regfile_dump.sv | 113 +++++++++++
 tb/tb_regfile_dump.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// regfile_dump_if: byte-wide valid/ready stream from the dumper to the debug UART
interface regfile_dump_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: walks a wrapping register range and streams 5-byte records (addr, data MSB-first)
module regfile_dump #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   last_addr,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    regfile_dump_if.master      strm,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {IDLE, FETCH, SEND_ADDR, SEND_DATA, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs;

    assign hs             = valid_q && strm.out_ready;
    assign rd_addr        = cur_q;
    assign strm.out_valid = valid_q;
    assign strm.out_data  = data_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // Next-state logic; outputs are derived from the next state so they come straight from flops
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = start_addr;
                    last_d  = last_addr;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shreg_d = rd_data;
                state_d = SEND_ADDR;
            end
            SEND_ADDR: begin
                if (hs) begin
                    bcnt_d  = 2'd0;
                    state_d = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (hs) begin
                    shreg_d = {shreg_q[DATA_W-9:0], 8'h00};
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (cur_q == last_q) begin
                            state_d = DONE;
                        end else begin
                            cur_d   = ADDR_W'((int'(cur_q) + 1) % NUM_REGS);
                            state_d = FETCH;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == SEND_ADDR) || (state_d == SEND_DATA);
        data_d  = (state_d == SEND_ADDR) ? 8'(cur_d) :
                  (state_d == SEND_DATA) ? shreg_d[DATA_W-1 -: 8] : 8'h00;
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
    end

    // State and registered outputs; reset aborts any record in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench for regfile_dump with a behavioural register file
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  start_addr = '0;
    logic [4:0]  last_addr = '0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [31:0] regs [32];
    logic [7:0]  q [$];
    int          tests = 0;
    int          fails = 0;
    logic        stall = 1'b0;
    logic [7:0]  held = '0;

    regfile_dump_if strm();

    regfile_dump dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_addr(start_addr),
        .last_addr(last_addr),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .strm(strm),
        .busy(busy),
        .done(done)
    );

    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rec(input logic [4:0] a, input logic [31:0] v);
        q.push_back({3'b000, a});
        q.push_back(v[31:24]);
        q.push_back(v[23:16]);
        q.push_back(v[15:8]);
        q.push_back(v[7:0]);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks that stalled bytes hold
    always @(negedge clk) begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                tests++;
                if (!strm.out_valid || strm.out_data !== held) begin
                    fails++;
                    $display("FAIL hold: valid %b data %h, required valid 1 data %h", strm.out_valid, strm.out_data, held);
                end
            end
            if (strm.out_valid && strm.out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_byte: got %h with nothing expected", strm.out_data);
                end else begin
                    logic [7:0] e;
                    e = q.pop_front();
                    if (strm.out_data !== e) begin
                        fails++;
                        $display("FAIL byte: got %h expected %h at %0t", strm.out_data, e, $time);
                    end
                end
            end
            stall = strm.out_valid && !strm.out_ready;
            held  = strm.out_data;
        end
    end

    // Issues one dump, optionally with random backpressure, a register write and a stray start
    task automatic run_dump(input logic [4:0] sa, input logic [4:0] la, input int n, input bit bp,
                            input int wr_c, input logic [4:0] wr_a, input logic [31:0] wr_v, input int st_c);
        int c;
        int dc;
        start_addr = sa;
        last_addr  = la;
        start      = 1'b1;
        strm.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        start = 1'b0;
        dc = 0;
        c = 1;
        chk("busy_rise", 32'(busy), 32'd1);
        while (dc == 0 && c <= 30 * n + 20) begin
            if (c == wr_c) regs[wr_a] = wr_v;
            if (c == st_c) begin
                start      = 1'b1;
                start_addr = sa + 5'd9;
            end
            if (done) begin
                dc = c;
                chk("busy_in_done", 32'(busy), 32'd1);
            end else if (c <= 6 * n) begin
                chk("busy_mid", 32'(busy), 32'd1);
            end
            tick();
            start = 1'b0;
            strm.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            c++;
        end
        chk("done_seen", 32'(dc != 0), 32'd1);
        if (!bp) chk("done_cycle", dc, 6 * n + 1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        tick();
        chk("start_ignored", 32'(busy), 32'd0);
        chk("drained", q.size(), 32'd0);
        strm.out_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
        strm.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(strm.out_valid), 32'd0);
        chk("rst_data", 32'(strm.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        reset = 1'b0;
        tick();

        regs[5] = 32'hDEADBEEF;
        q.push_back(8'h05);
        q.push_back(8'hDE);
        q.push_back(8'hAD);
        q.push_back(8'hBE);
        q.push_back(8'hEF);
        run_dump(5'd5, 5'd5, 1, 1'b0, 0, 5'd0, 32'h0, 0);

        for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
        for (int i = 0; i < 32; i++) push_rec(5'(i), 32'h01010101 * i);
        run_dump(5'd0, 5'd31, 32, 1'b0, 0, 5'd0, 32'h0, 0);

        for (int i = 0; i < 32; i++) push_rec(5'(i), 32'h01010101 * i);
        run_dump(5'd0, 5'd31, 32, 1'b1, 0, 5'd0, 32'h0, 0);

        push_rec(5'd30, 32'h1E1E1E1E);
        push_rec(5'd31, 32'h1F1F1F1F);
        push_rec(5'd0, 32'h00000000);
        push_rec(5'd1, 32'h01010101);
        run_dump(5'd30, 5'd1, 4, 1'b0, 0, 5'd0, 32'h0, 25);

        push_rec(5'd2, 32'h02020202);
        push_rec(5'd3, 32'h03030303);
        push_rec(5'd4, 32'h04040404);
        push_rec(5'd5, 32'h05050505);
        run_dump(5'd2, 5'd5, 4, 1'b0, 8, 5'd3, 32'h12345678, 10);
        push_rec(5'd3, 32'h12345678);
        run_dump(5'd3, 5'd3, 1, 1'b0, 0, 5'd0, 32'h0, 0);

        q.push_back(8'h02);
        q.push_back(8'h02);
        q.push_back(8'h02);
        start_addr = 5'd2;
        last_addr  = 5'd4;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("third_byte", 32'(strm.out_data), 32'h02);
        reset = 1'b1;
        strm.out_ready = 1'b0;
        tick();
        reset = 1'b0;
        strm.out_ready = 1'b1;
        chk("abort_valid", 32'(strm.out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("abort_quiet", 32'({strm.out_valid, done}), 32'd0);
            tick();
        end
        chk("abort_drained", q.size(), 32'd0);
        push_rec(5'd2, 32'h02020202);
        run_dump(5'd2, 5'd2, 1, 1'b0, 0, 5'd0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
